// File: rtl/bit_serial_pkg.sv
// Shared definitions for the serial bit interface: FSM encoding and parity modes.
// Both the transmitting and the sampling blocks import this package.
package bit_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and shifts it out
// one bit per clock on a registered d_out, with an optional trailing even-parity bit.
module bit_serializer
  import bit_serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned PARITY    = PAR_NONE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             d_out,
  output logic             frame_out,
  output logic             last_out
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam bit               HAS_PAR  = (PARITY == PAR_EVEN);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               par_q, par_d;
  logic               d_d, frame_d, last_d;
  logic               accept;

  // First bit of an incoming word / next bit of the held word, and what remains after each.
  logic               load_bit, next_bit;
  logic [WIDTH-1:0]   load_rem, shift_rem;

  generate
    if (MSB_FIRST) begin : g_msb
      assign load_bit  = data_in[WIDTH-1];
      assign load_rem  = {data_in[WIDTH-2:0], 1'b0};
      assign next_bit  = shreg_q[WIDTH-1];
      assign shift_rem = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign load_bit  = data_in[0];
      assign load_rem  = {1'b0, data_in[WIDTH-1:1]};
      assign next_bit  = shreg_q[0];
      assign shift_rem = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  // Ready while idle or while the final bit of the current frame is on the wire.
  assign ready_out = (state_q == S_IDLE) || (state_q == S_PAR) ||
                     ((state_q == S_SHIFT) && (cnt_q == LAST_IDX) && !HAS_PAR);
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      d_out     <= 1'b0;
      frame_out <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      d_out     <= d_d;
      frame_out <= frame_d;
      last_out  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    d_d     = 1'b0;
    frame_d = 1'b0;
    last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_SHIFT: begin
        if (cnt_q != LAST_IDX) begin
          shreg_d = shift_rem;
          d_d     = next_bit;
          cnt_d   = cnt_q + CNT_W'(1);
          frame_d = 1'b1;
          last_d  = ((cnt_q + CNT_W'(1)) == LAST_IDX) && !HAS_PAR;
        end else if (HAS_PAR) begin
          state_d = S_PAR;
          d_d     = par_q;
          frame_d = 1'b1;
          last_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_PAR: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A handshake always starts a fresh frame, overriding the end-of-frame decision.
    if (accept) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      shreg_d = load_rem;
      par_d   = ^data_in;
      d_d     = load_bit;
      frame_d = 1'b1;
      last_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three configurations (MSB-first, LSB-first, MSB-first with parity)
// checked every cycle against a frame-list model plus directed literal expectations.
module tb_bit_serializer;

  logic       clk;
  logic       rst_n;
  logic       vin  [3];
  logic [7:0] din  [3];
  logic       rdy  [3];
  logic       dout [3];
  logic       frm  [3];
  logic       lst  [3];

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  check_en = 1'b0;

  // Model: bit list of the frame in flight and the index of the bit currently on the wire.
  bit  fb  [3][9];
  int  pos [3] = '{-1, -1, -1};
  int  cp;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .data_in(din[0]), .valid_in(vin[0]),
    .ready_out(rdy[0]), .d_out(dout[0]), .frame_out(frm[0]), .last_out(lst[0]));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .data_in(din[1]), .valid_in(vin[1]),
    .ready_out(rdy[1]), .d_out(dout[1]), .frame_out(frm[1]), .last_out(lst[1]));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY(1)) u_par (
    .clk(clk), .rst_n(rst_n), .data_in(din[2]), .valid_in(vin[2]),
    .ready_out(rdy[2]), .d_out(dout[2]), .frame_out(frm[2]), .last_out(lst[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit cfg_msb(input int k);
    return k != 1;
  endfunction

  function automatic int cfg_len(input int k);
    return (k == 2) ? 9 : 8;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update at each active edge (and immediately on reset).
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) pos[k] = -1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (vin[k] && (pos[k] < 0 || pos[k] == cfg_len(k) - 1)) begin
          for (int i = 0; i < 8; i++) fb[k][i] = cfg_msb(k) ? din[k][7-i] : din[k][i];
          fb[k][8] = ($countones(din[k]) % 2) == 1;
          pos[k]   = 0;
        end else if (pos[k] >= 0) begin
          pos[k]++;
          if (pos[k] == cfg_len(k)) pos[k] = -1;
        end
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      for (int k = 0; k < 3; k++) begin
        cp = pos[k];
        chk($sformatf("d_out[%0d]", k), 32'(dout[k]), (cp >= 0) ? 32'(fb[k][cp]) : 32'd0);
        chk($sformatf("frame_out[%0d]", k), 32'(frm[k]), 32'(cp >= 0));
        chk($sformatf("last_out[%0d]", k), 32'(lst[k]), 32'(cp == cfg_len(k) - 1));
        chk($sformatf("ready_out[%0d]", k), 32'(rdy[k]), 32'(cp < 0 || cp == cfg_len(k) - 1));
      end
    end
  end

  // Presents w0 on instance k and records n cycles of outputs, first cycle in the MSB.
  // With b2b set, w1 is presented from cycle c2 and held until the first frame ends.
  task automatic collect(input int k, input int n, input logic [7:0] w0, input bit b2b,
                         input logic [7:0] w1, input int c2, input int flen,
                         output logic [31:0] bits, output logic [31:0] fmask,
                         output logic [31:0] lmask, output logic [31:0] rmask);
    bits = '0; fmask = '0; lmask = '0; rmask = '0;
    @(negedge clk);
    vin[k] = 1'b1;
    din[k] = w0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      bits  = {bits[30:0],  dout[k]};
      fmask = {fmask[30:0], frm[k]};
      lmask = {lmask[30:0], lst[k]};
      rmask = {rmask[30:0], rdy[k]};
      if (c == 1) begin
        vin[k] = 1'b0;
        din[k] = ~w0;
      end
      if (b2b && c == c2) begin
        vin[k] = 1'b1;
        din[k] = w1;
      end
      if (b2b && c == flen + 1) begin
        vin[k] = 1'b0;
        din[k] = ~w1;
      end
    end
  endtask

  logic [31:0] b, f, l, r;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vin[k] = 1'b0;
      din[k] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset ready[%0d]", k), 32'(rdy[k]), 32'd1);
      chk($sformatf("reset d_out[%0d]", k), 32'(dout[k]), 32'd0);
      chk($sformatf("reset frame[%0d]", k), 32'(frm[k]), 32'd0);
      chk($sformatf("reset last[%0d]", k), 32'(lst[k]), 32'd0);
    end
    #2 rst_n = 1'b1;
    check_en = 1'b1;

    // Single word, MSB first: 1,0,1,0,0,1,0,1 then idle.
    collect(0, 9, 8'hA5, 1'b0, 8'h00, 0, 8, b, f, l, r);
    chk("a5 bits",  b, 32'h14A);
    chk("a5 frame", f, 32'h1FE);
    chk("a5 last",  l, 32'h002);
    chk("a5 ready", r, 32'h003);

    // Back-to-back A5 then 3C with valid held: 16 contiguous frame cycles.
    collect(0, 17, 8'hA5, 1'b1, 8'h3C, 1, 8, b, f, l, r);
    chk("b2b bits",  b, 32'h14A78);
    chk("b2b frame", f, 32'h1FFFE);
    chk("b2b last",  l, 32'h00202);
    chk("b2b ready", r, 32'h00203);

    // LSB first: 0x01 then 0x80, the second raised mid-frame and held until accepted.
    collect(1, 17, 8'h01, 1'b1, 8'h80, 3, 8, b, f, l, r);
    chk("lsb bits",  b, 32'h10002);
    chk("lsb frame", f, 32'h1FFFE);
    chk("lsb last",  l, 32'h00202);
    chk("lsb ready", r, 32'h00203);

    // Even parity appended: 0x07 -> parity 1, 0x03 -> parity 0.
    collect(2, 10, 8'h07, 1'b0, 8'h00, 0, 9, b, f, l, r);
    chk("par07 bits",  b, 32'h01E);
    chk("par07 frame", f, 32'h3FE);
    chk("par07 last",  l, 32'h002);
    chk("par07 ready", r, 32'h003);
    collect(2, 10, 8'h03, 1'b0, 8'h00, 0, 9, b, f, l, r);
    chk("par03 bits",  b, 32'h00C);

    // Reset during bit 3 of 0xFF drops outputs at once; next frame is clean.
    @(negedge clk);
    vin[0] = 1'b1;
    din[0] = 8'hFF;
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre-reset frame", 32'(frm[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort d_out", 32'(dout[0]), 32'd0);
    chk("abort frame", 32'(frm[0]),  32'd0);
    chk("abort last",  32'(lst[0]),  32'd0);
    chk("abort ready", 32'(rdy[0]),  32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    collect(0, 9, 8'h81, 1'b0, 8'h00, 0, 8, b, f, l, r);
    chk("post-reset bits",  b, 32'h102);
    chk("post-reset frame", f, 32'h1FE);

    // Idle with valid low: nothing on the wire.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      din[0] = 8'(c * 37);
      chk("idle d_out", 32'(dout[0]), 32'd0);
      chk("idle frame", 32'(frm[0]),  32'd0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial transmitter that produces the 1-bit D stream consumed by the team's D flip-flop and serial-sampling blocks. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with an optional even-parity bit. It is the synthesizable source side of the serial bit interface; today that stream is driven by bench stimulus. It sits between any word-producing block and a single-bit registered sink.

## Interface
- WIDTH, 8, data word width in bits (2..32)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first
- PARITY, 0, 0 = no parity cycle, 1 = one even-parity bit appended after the data bits
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- data_in  input  WIDTH  word to transmit, sampled only on handshake
- valid_in  input  1  data_in is valid
- ready_out  output  1  block can accept a word this cycle
- d_out  output  1  serial bit, registered
- frame_out  output  1  d_out carries a frame bit this cycle, registered
- last_out  output  1  current d_out is the final bit of the frame, registered

## Operation
- FSM states:
  - IDLE: no transmission.
  - SHIFT: data bits.
  - PAR: parity bit; only when PARITY=1.
- Accept: at a rising edge with valid_in && ready_out, capture data_in into the shift register and compute the parity bit. Parity is the XOR of all data bits, so the total count of ones including parity is even.
- ready_out is combinational from state and counter:
  - 1 in IDLE.
  - 1 during the final frame cycle: the last SHIFT cycle when PARITY=0, or the PAR cycle when PARITY=1.
  - 0 otherwise.
- IDLE→SHIFT on accept.
- SHIFT: the bit counter counts WIDTH cycles.
  - After the last data bit, go to PAR if PARITY=1.
  - Otherwise, on an accept in the final cycle, go to SHIFT with the new word.
  - Otherwise go to IDLE.
- PAR: go to SHIFT on a new accept, else IDLE.
- Back-to-back words: zero gap cycles; frame_out stays high continuously.
- Outside a frame: d_out=0, frame_out=0, last_out=0.
- data_in is don't-care after acceptance.
- valid_in while ready_out=0 is ignored. The producer holds valid_in and data_in stable until accepted.
- Bit counter width is $clog2(WIDTH+1). It wraps to 0 on each new frame and never overflows.

## Timing
- Reset (rst_n=0, asynchronous, immediate):
  - state=IDLE, counter=0, shift register=0.
  - d_out=0, frame_out=0, last_out=0, ready_out=1.
- Latency: a word accepted at edge N drives its first bit from edge N to edge N+1, so it is visible the cycle after the handshake.
- Frame length: WIDTH cycles, or WIDTH+1 cycles with PARITY=1. last_out is high for exactly one cycle, aligned with the final bit.
- Throughput: one word per WIDTH (+PARITY) cycles when valid_in is held high.
- Reset mid-frame: the frame is aborted and outputs drop the same instant. After rst_n deasserts, the block is in IDLE with ready_out=1; the partial word is never resumed.
- Final-cycle accept with simultaneous rst_n=0: reset wins; the word is not accepted.

## Structure
- Shared package bit_serial_pkg holds:
  - state encoding constants (S_IDLE, S_SHIFT, S_PAR);
  - parity mode constants (PAR_NONE=0, PAR_EVEN=1).
  The sampling-side blocks reuse the same package.
- Single module, no sub-module. The counter, shift register and parity logic are inline; the shift direction is selected by MSB_FIRST via generate.

## Test plan
- WIDTH=8, MSB_FIRST=1, PARITY=0, single word 0xA5 → d_out = 1,0,1,0,0,1,0,1 on the 8 cycles after accept; frame_out high for 8 cycles; last_out high on cycle 8 only; ready_out=0 on cycles 1–7.
- Back-to-back: 0xA5 then 0x3C with valid_in held → 16 contiguous frame_out cycles, bits 10100101 00111100; second accept occurs in cycle 8; last_out pulses on cycles 8 and 16.
- MSB_FIRST=0, word 0x01 → d_out = 1 then seven 0s; word 0x80 → seven 0s then 1.
- PARITY=1: word 0x07 → 8 data bits then parity bit 1, last_out on cycle 9; word 0x03 → parity bit 0.
- Reset mid-frame: assert rst_n=0 during bit 3 of 0xFF → d_out, frame_out and last_out go to 0 immediately and ready_out=1. After release, accept 0x81 → clean frame 1,0,0,0,0,0,0,1.
- Idle and ignored valid: valid_in=0 for 10 cycles → d_out=0, frame_out=0 throughout. Change data_in mid-frame → transmitted bits unaffected.
